// File: rtl/idu_stage_pkg.sv
// idu_stage_pkg: shared decode definitions for the instruction-decode stage.
//   - aluop_e   : ALU operation codes handed to the execute unit
//   - OPC_*     : RV32 base opcode constants (inst[6:0])
//   - MEM_*     : memory access size codes (funct3[1:0] of loads/stores)
package idu_stage_pkg;

    typedef enum logic [4:0] {
        ALU_NOP    = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_XOR    = 5'd3,
        ALU_OR     = 5'd4,
        ALU_AND    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_SLT    = 5'd9,
        ALU_SLTU   = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } aluop_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

endpackage

// File: rtl/idu_stage_dec.sv
// idu_dec: purely combinational RV32I(E)/M instruction decoder.
//   inst, pc            : instruction word and its address
//   rs1_val, rs2_val    : register operands (already bypassed by the caller)
//   rd_addr, aluop      : destination register and ALU operation
//   op1, op2, imm       : selected operands and the format immediate
//   jal..mem_size       : control flags for the execute/memory units
//   illegal             : instruction not supported by this configuration
//   op1_is_rs1/op2_is_rs2 : operand comes from the register file, so a
//                           later writeback to that register must refresh it
module idu_dec
    import idu_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV32E   = 1'b1,
    parameter bit EN_M    = 1'b0,
    parameter int ALUOP_W = 5
) (
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic [XLEN-1:0]    rs2_val,
    output logic [4:0]         rd_addr,
    output logic [ALUOP_W-1:0] aluop,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2,
    output logic [XLEN-1:0]    imm,
    output logic               jal,
    output logic               jalr,
    output logic               brch,
    output logic               mem_wren,
    output logic               mem_rden,
    output logic               mem_unsigned,
    output logic [1:0]         mem_size,
    output logic               illegal,
    output logic               op1_is_rs1,
    output logic               op2_is_rs2
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = inst[6:0];
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];
    assign rs1     = inst[19:15];
    assign rs2     = inst[24:20];
    assign rd_addr = inst[11:7];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [4:0]  op;
    logic [31:0] imm32;
    logic        bad, use_rs1, use_rs2, use_rd;
    logic        op1_pc, op1_zero, op2_reg;
    logic        f_jal, f_jalr, f_brch, f_wr, f_rd, f_uns;
    logic [1:0]  f_size;

    always_comb begin
        op       = ALU_NOP;
        imm32    = '0;
        bad      = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        op1_pc   = 1'b0;
        op1_zero = 1'b0;
        op2_reg  = 1'b0;
        f_jal    = 1'b0;
        f_jalr   = 1'b0;
        f_brch   = 1'b0;
        f_wr     = 1'b0;
        f_rd     = 1'b0;
        f_uns    = 1'b0;
        f_size   = '0;

        case (opcode)
            OPC_LUI: begin
                op       = ALU_ADD;
                imm32    = imm_u;
                op1_zero = 1'b1;
                use_rd   = 1'b1;
            end
            OPC_AUIPC: begin
                op     = ALU_ADD;
                imm32  = imm_u;
                op1_pc = 1'b1;
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                op     = ALU_ADD;
                imm32  = imm_j;
                op1_pc = 1'b1;
                f_jal  = 1'b1;
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                op      = ALU_ADD;
                imm32   = imm_i;
                f_jalr  = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                bad     = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                op      = ALU_ADD;
                imm32   = imm_b;
                f_brch  = 1'b1;
                op2_reg = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                op      = ALU_ADD;
                imm32   = imm_i;
                f_rd    = 1'b1;
                f_uns   = f3[2];
                f_size  = f3[1:0];
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                // lwu does not exist on RV32; lbu/lhu do
                bad     = !(f3[1:0] inside {MEM_BYTE, MEM_HALF, MEM_WORD}) ||
                          (f3[1:0] == MEM_WORD && f3[2]);
            end
            OPC_STORE: begin
                op      = ALU_ADD;
                imm32   = imm_s;
                f_wr    = 1'b1;
                f_size  = f3[1:0];
                op2_reg = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = f3[2] || !(f3[1:0] inside {MEM_BYTE, MEM_HALF, MEM_WORD});
            end
            OPC_OPIMM: begin
                imm32   = imm_i;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                case (f3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        op  = ALU_SLL;
                        bad = (f7 != 7'h00);
                    end
                    default: begin
                        if (f7 == 7'h00)      op = ALU_SRL;
                        else if (f7 == 7'h20) op = ALU_SRA;
                        else                  bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                op2_reg = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'b000)      op = ALU_SUB;
                    else if (f3 == 3'b101) op = ALU_SRA;
                    else                   bad = 1'b1;
                end else if (f7 == 7'h01 && EN_M) begin
                    // M-extension codes are laid out in funct3 order from ALU_MUL
                    op = ALU_MUL | {2'b00, f3};
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        if (RV32E && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd_addr[4])))
            bad = 1'b1;

        if (bad) begin
            op     = ALU_NOP;
            f_jal  = 1'b0;
            f_jalr = 1'b0;
            f_brch = 1'b0;
            f_wr   = 1'b0;
            f_rd   = 1'b0;
            f_uns  = 1'b0;
            f_size = '0;
        end
    end

    assign imm          = XLEN'($signed(imm32));
    assign op1          = op1_zero ? '0 : (op1_pc ? pc : rs1_val);
    assign op2          = op2_reg ? rs2_val : imm;
    assign op1_is_rs1   = !op1_zero && !op1_pc;
    assign op2_is_rs2   = op2_reg;
    assign aluop        = ALUOP_W'(op);
    assign jal          = f_jal;
    assign jalr         = f_jalr;
    assign brch         = f_brch;
    assign mem_wren     = f_wr;
    assign mem_rden     = f_rd;
    assign mem_unsigned = f_uns;
    assign mem_size     = f_size;
    assign illegal      = bad;

endmodule

// File: rtl/idu_stage.sv
// idu_stage: instruction-decode pipeline stage with a one-entry skid buffer.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_flush                 : drop every held entry and the current input
//   i_ifu_*/o_idu_ready     : upstream handshake, pc and instruction
//   o_idu_rs1/rs2_addr      : register-file read addresses (combinational)
//   i_reg_rs1/rs2_data      : register-file read data for the current input
//   i_wb_en/addr/data       : writeback port, bypassed into new and held entries
//   o_idu_valid/i_exu_ready : downstream handshake
//   o_idu_*                 : registered decode results
module idu_stage
    import idu_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV32E   = 1'b1,
    parameter bit EN_M    = 1'b0,
    parameter int ALUOP_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_ifu_valid,
    output logic               o_idu_ready,
    input  logic [XLEN-1:0]    i_ifu_pc,
    input  logic [31:0]        i_ifu_inst,
    output logic [4:0]         o_idu_rs1_addr,
    output logic [4:0]         o_idu_rs2_addr,
    input  logic [XLEN-1:0]    i_reg_rs1_data,
    input  logic [XLEN-1:0]    i_reg_rs2_data,
    input  logic               i_wb_en,
    input  logic [4:0]         i_wb_addr,
    input  logic [XLEN-1:0]    i_wb_data,
    output logic               o_idu_valid,
    input  logic               i_exu_ready,
    output logic [XLEN-1:0]    o_idu_pc,
    output logic [31:0]        o_idu_inst,
    output logic [4:0]         o_idu_rd_addr,
    output logic [ALUOP_W-1:0] o_idu_aluop,
    output logic [XLEN-1:0]    o_idu_op1,
    output logic [XLEN-1:0]    o_idu_op2,
    output logic [XLEN-1:0]    o_idu_imm,
    output logic               o_idu_jal,
    output logic               o_idu_jalr,
    output logic               o_idu_brch,
    output logic               o_idu_mem_wren,
    output logic               o_idu_mem_rden,
    output logic               o_idu_mem_unsigned,
    output logic [1:0]         o_idu_mem_size,
    output logic               o_idu_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [31:0]        inst;
        logic [4:0]         rd;
        logic [ALUOP_W-1:0] aluop;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [XLEN-1:0]    imm;
        logic               jal;
        logic               jalr;
        logic               brch;
        logic               mem_wren;
        logic               mem_rden;
        logic               mem_unsigned;
        logic [1:0]         mem_size;
        logic               illegal;
        logic               op1_rs;
        logic               op2_rs;
    } entry_t;

    // Refresh register-sourced operands of a held entry with a writeback
    function automatic entry_t wb_apply(entry_t e, logic en, logic [4:0] a,
                                        logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (en && a != 5'd0) begin
            if (e.op1_rs && e.inst[19:15] == a) r.op1 = d;
            if (e.op2_rs && e.inst[24:20] == a) r.op2 = d;
        end
        return r;
    endfunction

    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    entry_t          new_e, out_q, skid_q, out_upd, skid_upd;
    logic            out_valid, skid_valid;
    logic            accept, drain;

    assign rs1            = i_ifu_inst[19:15];
    assign rs2            = i_ifu_inst[24:20];
    assign o_idu_rs1_addr = rs1;
    assign o_idu_rs2_addr = rs2;

    assign rs1_val = (i_wb_en && i_wb_addr == rs1 && rs1 != 5'd0) ? i_wb_data : i_reg_rs1_data;
    assign rs2_val = (i_wb_en && i_wb_addr == rs2 && rs2 != 5'd0) ? i_wb_data : i_reg_rs2_data;

    assign new_e.pc   = i_ifu_pc;
    assign new_e.inst = i_ifu_inst;

    idu_dec #(
        .XLEN    (XLEN),
        .RV32E   (RV32E),
        .EN_M    (EN_M),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .inst         (i_ifu_inst),
        .pc           (i_ifu_pc),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_addr      (new_e.rd),
        .aluop        (new_e.aluop),
        .op1          (new_e.op1),
        .op2          (new_e.op2),
        .imm          (new_e.imm),
        .jal          (new_e.jal),
        .jalr         (new_e.jalr),
        .brch         (new_e.brch),
        .mem_wren     (new_e.mem_wren),
        .mem_rden     (new_e.mem_rden),
        .mem_unsigned (new_e.mem_unsigned),
        .mem_size     (new_e.mem_size),
        .illegal      (new_e.illegal),
        .op1_is_rs1   (new_e.op1_rs),
        .op2_is_rs2   (new_e.op2_rs)
    );

    assign out_upd  = wb_apply(out_q,  i_wb_en, i_wb_addr, i_wb_data);
    assign skid_upd = wb_apply(skid_q, i_wb_en, i_wb_addr, i_wb_data);

    // Ready depends only on skid occupancy, so it never waits on i_exu_ready
    assign o_idu_ready = !skid_valid;
    assign accept      = i_ifu_valid && !skid_valid;
    assign drain       = out_valid && i_exu_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (i_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            out_q  <= out_upd;
            skid_q <= skid_upd;
            if (!out_valid || drain) begin
                // Skid can only be full when no input was accepted, so it wins
                if (skid_valid) begin
                    out_q      <= skid_upd;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_q     <= new_e;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= new_e;
                skid_valid <= 1'b1;
            end
        end
    end

    assign o_idu_valid        = out_valid;
    assign o_idu_pc           = out_q.pc;
    assign o_idu_inst         = out_q.inst;
    assign o_idu_rd_addr      = out_q.rd;
    assign o_idu_aluop        = out_q.aluop;
    assign o_idu_op1          = out_q.op1;
    assign o_idu_op2          = out_q.op2;
    assign o_idu_imm          = out_q.imm;
    assign o_idu_jal          = out_q.jal;
    assign o_idu_jalr         = out_q.jalr;
    assign o_idu_brch         = out_q.brch;
    assign o_idu_mem_wren     = out_q.mem_wren;
    assign o_idu_mem_rden     = out_q.mem_rden;
    assign o_idu_mem_unsigned = out_q.mem_unsigned;
    assign o_idu_mem_size     = out_q.mem_size;
    assign o_idu_illegal      = out_q.illegal;

endmodule
